// File: rtl/alu_cmd_engine.sv
// Serial-command ALU engine: 3-cycle opcode/operand capture, multi-cycle execute,
// single-cycle result presentation with done, abort reporting with err.
module alu_cmd_engine #(
  parameter int DATA_WIDTH  = 8,
  parameter int EXEC_CYCLES = 1,
  parameter int SATURATE    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  opcode_valid,
  input  logic                  opcode,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  overflow,
  output logic                  zero,
  output logic                  err
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [W-1:0] W_VAL = W'(W);

  typedef enum logic [2:0] {IDLE, OP1, OP2, EXEC, DONE, ABORT} state_t;

  typedef struct packed {
    logic [W-1:0] res;
    logic         ovf;
    logic         zero;
  } res_t;

  state_t        state, state_nxt;
  logic [W-1:0]  a_q, b_q;
  logic [2:0]    op_q;
  logic [CW-1:0] cnt;
  res_t          res_q, alu;

  logic [W:0]     sum;
  logic [2*W-1:0] shl_full;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    err       = (state == ABORT);
    result    = done ? res_q.res : '0;
    overflow  = done & res_q.ovf;
    zero      = done & res_q.zero;
    case (state)
      IDLE:    if (opcode_valid) state_nxt = OP1;
      OP1:     state_nxt = opcode_valid ? OP2  : ABORT;
      OP2:     state_nxt = opcode_valid ? EXEC : ABORT;
      EXEC:    if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      ABORT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Each command field is only sampled in its own command cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      cnt   <= '0;
      res_q <= '0;
    end else begin
      case (state)
        IDLE: if (opcode_valid) begin
          a_q     <= data;
          op_q[0] <= opcode;
        end
        OP1: if (opcode_valid) begin
          b_q     <= data;
          op_q[1] <= opcode;
        end
        OP2: if (opcode_valid) begin
          op_q[2] <= opcode;
          cnt     <= CW'(EXEC_CYCLES - 1);
        end
        EXEC: begin
          if (cnt != '0) cnt   <= cnt - 1'b1;
          else           res_q <= alu;
        end
        default: ;
      endcase
    end
  end

  assign sum      = {1'b0, a_q} + {1'b0, b_q};
  assign shl_full = {{W{1'b0}}, a_q} << b_q;

  always_comb begin
    alu = '0;
    case (op_q)
      3'd0: begin
        alu.res = sum[W-1:0];
        alu.ovf = sum[W];
        if (SATURATE != 0 && sum[W]) alu.res = '1;
      end
      3'd1: begin
        alu.res = a_q - b_q;
        alu.ovf = (a_q < b_q);
        if (SATURATE != 0 && a_q < b_q) alu.res = '0;
      end
      3'd2: alu.res = {{(W-1){1'b0}}, ^{a_q, b_q}};
      3'd3: alu.res = (a_q == b_q) ? W'(1) : (a_q > b_q) ? W'(2) : '0;
      3'd4: alu.res = a_q & b_q;
      3'd5: alu.res = a_q | b_q;
      3'd6: alu.res = a_q ^ b_q;
      default: begin
        // Shift amounts of W or more push every bit of A out.
        if (b_q >= W_VAL) begin
          alu.res = '0;
          alu.ovf = |a_q;
        end else begin
          alu.res = shl_full[W-1:0];
          alu.ovf = |shl_full[2*W-1:W];
        end
      end
    endcase
    alu.zero = (alu.res == '0);
  end
endmodule

// File: tb/tb_alu_cmd_engine.sv
// Bench: two engine instances (EXEC_CYCLES=1 wrap, EXEC_CYCLES=4 saturate) on shared stimulus,
// checked every cycle against a cycle-count reference model plus literal expectations.
module tb_alu_cmd_engine;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       opcode_valid = 1'b0;
  logic       opcode = 1'b0;
  logic [7:0] data = 8'h00;

  logic [1:0]      busy_v, done_v, ovf_v, zero_v, err_v;
  logic [1:0][7:0] res_v;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model state: -1 idle, -2 abort cycle, otherwise cycles since command cycle 0.
  int         mt[2] = '{-1, -1};
  int         ma[2], mb[2];
  logic [2:0] mop[2];

  int         lat[2];
  logic [7:0] rr[2];
  bit         ro[2], rz[2];

  always #5 clk = ~clk;

  alu_cmd_engine #(.DATA_WIDTH(8), .EXEC_CYCLES(1), .SATURATE(0)) u_a (
    .clk(clk), .reset(reset), .opcode_valid(opcode_valid), .opcode(opcode), .data(data),
    .busy(busy_v[0]), .done(done_v[0]), .result(res_v[0]), .overflow(ovf_v[0]),
    .zero(zero_v[0]), .err(err_v[0]));

  alu_cmd_engine #(.DATA_WIDTH(8), .EXEC_CYCLES(4), .SATURATE(1)) u_b (
    .clk(clk), .reset(reset), .opcode_valid(opcode_valid), .opcode(opcode), .data(data),
    .busy(busy_v[1]), .done(done_v[1]), .result(res_v[1]), .overflow(ovf_v[1]),
    .zero(zero_v[1]), .err(err_v[1]));

  function automatic int exk(int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic void alu_ref(input logic [2:0] op, input int a, input int b, input bit sat,
                                  output int r, output bit ov);
    int full;
    ov = 1'b0;
    case (op)
      3'd0: begin r = a + b; ov = (r > 255); if (ov) r = sat ? 255 : r - 256; end
      3'd1: begin ov = (a < b); r = ov ? (sat ? 0 : a - b + 256) : a - b; end
      3'd2: r = ($countones(a) + $countones(b)) % 2;
      3'd3: r = (a == b) ? 1 : (a > b) ? 2 : 0;
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = a ^ b;
      default: begin
        if (b >= 8) begin r = 0; ov = (a != 0); end
        else begin full = a * (1 << b); r = full % 256; ov = (full >= 256); end
      end
    endcase
  endfunction

  // {busy, done, result, overflow, zero, err}
  function automatic logic [12:0] mexp(int k);
    int r;
    bit ov;
    if (mt[k] == -1) return 13'h0;
    if (mt[k] == -2) return 13'h1001;
    if (mt[k] == 3 + exk(k)) begin
      alu_ref(mop[k], ma[k], mb[k], k == 1, r, ov);
      return {1'b1, 1'b1, 8'(r), ov, (r == 0), 1'b0};
    end
    return 13'h1000;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        mt[k] = -1; ma[k] = 0; mb[k] = 0; mop[k] = 3'd0;
      end else if (mt[k] == -1) begin
        if (opcode_valid) begin ma[k] = data; mop[k][0] = opcode; mt[k] = 1; end
      end else if (mt[k] == 1) begin
        if (opcode_valid) begin mb[k] = data; mop[k][1] = opcode; mt[k] = 2; end
        else mt[k] = -2;
      end else if (mt[k] == 2) begin
        if (opcode_valid) begin mop[k][2] = opcode; mt[k] = 3; end
        else mt[k] = -2;
      end else if (mt[k] == -2 || mt[k] == 3 + exk(k)) begin
        mt[k] = -1;
      end else begin
        mt[k]++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++)
        chk($sformatf("cycle_dut%0d", k),
            {busy_v[k], done_v[k], res_v[k], ovf_v[k], zero_v[k], err_v[k]}, mexp(k));
    end
  end

  task automatic drain();
    @(posedge clk); #1;
    opcode_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  // Drives one command, jitters opcode_valid during EXEC/DONE, records first done per instance.
  task automatic run_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    lat[0] = -1; lat[1] = -1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      opcode_valid = 1'b1;
      opcode = op[c];
      data = (c == 0) ? a : (c == 1) ? b : 8'($urandom);
    end
    @(posedge clk); #1;
    opcode_valid = 1'b0;
    data = 8'($urandom);
    for (int c = 3; c < 30; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++)
        if (done_v[k] && lat[k] < 0) begin
          lat[k] = c; rr[k] = res_v[k]; ro[k] = ovf_v[k]; rz[k] = zero_v[k];
        end
      if (lat[0] >= 0 && lat[1] >= 0) break;
      @(posedge clk); #1;
      opcode_valid = 1'($urandom);
      opcode = 1'($urandom);
      data = 8'($urandom);
    end
    drain();
  endtask

  task automatic expect_res(input string nm, input int k, input int el, input int er,
                            input bit eo, input bit ez);
    chk({nm, "_lat"}, lat[k], el);
    chk({nm, "_res"}, rr[k], er);
    chk({nm, "_ovf"}, ro[k], eo);
    chk({nm, "_zero"}, rz[k], ez);
  endtask

  initial begin
    int r;
    bit ov;
    int dcount;

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++)
      chk($sformatf("reset_out%0d", k),
          {busy_v[k], done_v[k], res_v[k], ovf_v[k], zero_v[k], err_v[k]}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk_en = 1'b1;

    alu_ref(3'd0, 200, 100, 1'b0, r, ov); chk("model_add", {r, 1'(ov)}, {32'd44, 1'b1});
    alu_ref(3'd7, 8'h81, 1, 1'b0, r, ov); chk("model_shl", {r, 1'(ov)}, {32'd2, 1'b1});
    alu_ref(3'd1, 5, 9, 1'b1, r, ov);     chk("model_subsat", {r, 1'(ov)}, {32'd0, 1'b1});

    run_cmd(3'd0, 8'd200, 8'd100);
    expect_res("add_a", 0, 4, 44, 1, 0);
    expect_res("add_b", 1, 7, 255, 1, 0);
    run_cmd(3'd1, 8'd5, 8'd9);
    expect_res("sub_a", 0, 4, 252, 1, 0);
    expect_res("sub_b", 1, 7, 0, 1, 1);
    run_cmd(3'd3, 8'h33, 8'h33);  expect_res("comp_eq", 0, 4, 1, 0, 0);
    run_cmd(3'd3, 8'h40, 8'h33);  expect_res("comp_gt", 1, 7, 2, 0, 0);
    run_cmd(3'd7, 8'h81, 8'd1);   expect_res("shl1", 0, 4, 2, 1, 0);
    run_cmd(3'd7, 8'h81, 8'd8);   expect_res("shl8", 1, 7, 0, 1, 1);
    run_cmd(3'd2, 8'h07, 8'h00);  expect_res("par", 0, 4, 1, 0, 0);

    // Abort in OP2, then an immediate ADD 1+1.
    @(posedge clk); #1; opcode_valid = 1'b1; opcode = 1'b0; data = 8'd9;
    @(posedge clk); #1; data = 8'd3;
    @(posedge clk); #1; opcode_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_err", err_v, 2'b11);
    chk("abort_done", done_v, 2'b00);
    run_cmd(3'd0, 8'd1, 8'd1);
    expect_res("post_abort_a", 0, 4, 2, 0, 0);
    expect_res("post_abort_b", 1, 7, 2, 0, 0);

    // Reset pulse while u_b is in EXEC.
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1; opcode_valid = 1'b1; opcode = 1'b0; data = 8'd3 + 8'(c);
    end
    @(posedge clk); #1; opcode_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("reset_exec_busy", busy_v, 2'b00);
    dcount = 0;
    repeat (10) begin @(negedge clk); dcount += int'(done_v[1]); end
    chk("reset_exec_nodone", dcount, 0);

    // opcode_valid held high across two commands on u_b.
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      opcode_valid = 1'b1;
      opcode = 1'($urandom);
      data = 8'($urandom);
      case (c)
        0: begin opcode = 1'b0; data = 8'hF0; end
        1: begin opcode = 1'b1; data = 8'h0F; end
        2: opcode = 1'b1;
        8: begin opcode = 1'b0; data = 8'hF0; end
        9: begin opcode = 1'b0; data = 8'h0F; end
        10: opcode = 1'b1;
        default: ;
      endcase
      @(negedge clk);
      if (c == 7)  chk("b2b_xor", {done_v[1], res_v[1], zero_v[1]}, {1'b1, 8'hFF, 1'b0});
      if (c == 8)  chk("b2b_gap", done_v[1], 0);
      if (c == 15) chk("b2b_and", {done_v[1], res_v[1], zero_v[1]}, {1'b1, 8'h00, 1'b1});
    end
    drain();

    repeat (3000) begin
      @(posedge clk); #1;
      opcode_valid = ($urandom % 4) != 0;
      opcode = 1'($urandom);
      data = 8'($urandom);
      reset = ($urandom % 100) == 0;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    drain();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_cmd_engine.md
Name: alu_cmd_engine

Overview:
- Parametrised successor to the team's serial-opcode ALU controller.
- Accepts a 3-cycle serial command on `opcode_valid`/`opcode`/`data`:
  - 3-bit opcode, LSB first.
  - Operand A on command cycle 0, operand B on command cycle 1.
- Executes one of 8 operations over a configurable execution latency, then presents result and flags for one cycle with `done`.
- Adds over the previous generation: wider opcode space, optional saturation, zero flag, abort detection with `err`, and a `busy` indication.

Parameters:
- DATA_WIDTH, 8, operand/result width (>=4).
- EXEC_CYCLES, 1, cycles spent in EXEC (>=1).
- SATURATE, 0, 1 = ADD/SUB clamp on overflow; 0 = wrap.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- opcode_valid  input  1  high on each of the 3 command cycles.
- opcode  input  1  serial opcode bit; command cycle k carries op[k].
- data  input  DATA_WIDTH  operand: A on cycle 0, B on cycle 1, ignored on cycle 2.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; result and flags valid only while high.
- result  output  DATA_WIDTH  operation result; 0 when done=0.
- overflow  output  1  per-op overflow; 0 when done=0.
- zero  output  1  result==0; 0 when done=0.
- err  output  1  one-cycle pulse after an aborted command.

Behaviour:
- Reset: sampled at posedge with reset=1.
  - State goes to IDLE; A, B, op, counter and result register clear to 0.
  - All outputs read 0 in the following cycle.
  - Reset overrides every state, including mid-command and EXEC; no done or err is produced for the killed command.
- States: IDLE, OP1, OP2, EXEC, DONE, ABORT. Outputs are decoded from state; result and flags come from registers.
- IDLE:
  - opcode_valid=1: A<=data, op[0]<=opcode, go to OP1.
  - Otherwise stay.
- OP1:
  - opcode_valid=1: B<=data, op[1]<=opcode, go to OP2.
  - Otherwise go to ABORT.
- OP2:
  - opcode_valid=1: op[2]<=opcode, counter<=EXEC_CYCLES-1, go to EXEC.
  - Otherwise go to ABORT.
- EXEC:
  - counter!=0: decrement, stay.
  - counter==0: register result/overflow/zero, go to DONE.
  - opcode_valid is ignored.
- DONE: done=1 with result/overflow/zero driven from registers for one cycle; go to IDLE. opcode_valid is ignored.
- ABORT: err=1 for one cycle; go to IDLE. opcode_valid is ignored. A, B and op are not cleared.
- Latency: first command cycle = cycle 0; done is high in cycle 3+EXEC_CYCLES.
- Back-to-back: the earliest next command cycle 0 is the cycle after DONE, i.e. IDLE. With opcode_valid held high continuously, a new command starts at every IDLE.
- Operations (unsigned, W=DATA_WIDTH):
  - 000 ADD: W+1-bit sum; overflow=carry out. SATURATE=1 and overflow: result=all ones.
  - 001 SUB: A-B mod 2^W; overflow=(A<B). SATURATE=1 and overflow: result=0.
  - 010 PAR: result[0]=XOR-reduce of A and B concatenated; other bits 0; overflow=0.
  - 011 COMP: result=1 if A==B, 2 if A>B, 0 if A<B; overflow=0.
  - 100 AND, 101 OR, 110 XOR: bitwise; overflow=0.
  - 111 SHL:
    - B<W: result=A<<B; overflow=1 iff any 1-bit is shifted out.
    - B>=W: result=0; overflow=(A!=0).
- zero: computed on the final (post-saturation) result.
- Command fields are captured only in their own command cycle; data changes in other cycles have no effect.

Test Plan:
- W=8, SATURATE=0, ADD A=200 B=100 -> cycle 4: done=1, result=44, overflow=1, zero=0, busy=1; cycle 5: done=0, result=0, busy=0.
- SUB A=5 B=9 -> SATURATE=0: result=252, overflow=1. SATURATE=1: result=0, overflow=1, zero=1.
- COMP 0x33 vs 0x33 -> result=0x01. COMP 0x40 vs 0x33 -> result=0x02. SHL A=0x81 B=1 -> result=0x02, overflow=1. SHL A=0x81 B=8 -> result=0, overflow=1, zero=1. PAR A=0x07 B=0x00 -> result=1.
- Abort: opcode_valid low in OP2 -> err=1 exactly one cycle, no done. An immediately following ADD 1+1 -> result=2, overflow=0.
- Reset high for one cycle during EXEC (EXEC_CYCLES=4) -> next cycle busy=0, and done never pulses. Toggling opcode_valid during EXEC and DONE has no effect on result.
- EXEC_CYCLES=4, opcode_valid held high across two commands (XOR 0xF0^0x0F, then AND 0xF0&0x0F) -> done at cycles 7 and 15 with results 0xFF and 0x00 (zero=1).
